// File: rtl/m_wishbone_uarttx.sv
// Wishbone classic slave UART transmitter (8N1) with a small TX FIFO and a status register.
// The core pushes bytes through DATA and polls STATUS; irq requests more data once everything has drained.
module m_wishbone_uarttx #(
  parameter int DIVISOR      = 434,
  parameter int FIFOADRWIDTH = 2
) (
  input  logic        CLK_I,
  input  logic        RST_I,
  input  logic        STB_I,
  input  logic        WE_I,
  input  logic        ADR_I,
  input  logic [3:0]  SEL_I,
  input  logic [31:0] DAT_I,
  output logic        ACK_O,
  output logic [31:0] DAT_O,
  output logic        TXD,
  output logic        irq
);

  localparam int DEPTH_INT = 1 << FIFOADRWIDTH;
  localparam int TW        = $clog2(DIVISOR);
  localparam logic [FIFOADRWIDTH:0]   DEPTH   = (FIFOADRWIDTH+1)'(DEPTH_INT);
  localparam logic [FIFOADRWIDTH:0]   CNT_ONE = (FIFOADRWIDTH+1)'(1);
  localparam logic [FIFOADRWIDTH-1:0] PTR_ONE = FIFOADRWIDTH'(1);
  localparam logic [TW-1:0]           TMAX    = TW'(DIVISOR - 1);
  localparam logic [TW-1:0]           T_ONE   = TW'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  state_t state, state_next;

  logic [7:0]              mem [DEPTH_INT];
  logic [FIFOADRWIDTH-1:0] wr_ptr, rd_ptr;
  logic [FIFOADRWIDTH:0]   count;
  logic                    overflow;
  logic [TW-1:0]           timer;
  logic [2:0]              bitidx;
  logic [7:0]              shift;

  logic       full, empty, busy, tick;
  logic       acc, rd_setup, wr_data, rd_status;
  logic       pop, push, ovf_set;
  logic [7:0] status;
  logic       unused_bits;

  assign unused_bits = ^{SEL_I[3:1], DAT_I[31:8]};

  assign full  = (count == DEPTH);
  assign empty = (count == '0);
  assign busy  = (state != S_IDLE);
  assign irq   = empty & ~busy;
  assign tick  = (timer == '0);

  // Bus side effects occur only in the acknowledged cycle, so a held strobe acts once per ack pulse.
  assign acc       = STB_I & ACK_O;
  assign rd_setup  = STB_I & ~ACK_O & ~WE_I & ADR_I;
  assign wr_data   = acc & WE_I & ~ADR_I & SEL_I[0];
  assign rd_status = acc & ~WE_I & ADR_I;

  // A pop in the same cycle frees the slot, so a write into a full FIFO still succeeds then.
  assign push    = wr_data & (~full | pop);
  assign ovf_set = wr_data & full & ~pop;

  assign status = {4'(count), overflow, empty, full, busy};

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      ACK_O <= 1'b0;
      DAT_O <= '0;
    end else begin
      ACK_O <= STB_I & ~ACK_O;
      DAT_O <= rd_setup ? {24'b0, status} : 32'b0;
    end
  end

  always_ff @(posedge CLK_I) begin
    if (push) begin
      mem[wr_ptr] <= DAT_I[7:0];
    end
  end

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
      // A fresh overflow wins over the clear from a status read in the same cycle.
      if (ovf_set) begin
        overflow <= 1'b1;
      end else if (rd_status) begin
        overflow <= 1'b0;
      end
    end
  end

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (!empty) begin
          state_next = S_START;
        end
      end
      S_START: begin
        if (tick) begin
          state_next = S_DATA;
        end
      end
      S_DATA: begin
        if (tick && bitidx == 3'd7) begin
          state_next = S_STOP;
        end
      end
      S_STOP: begin
        if (tick) begin
          state_next = empty ? S_IDLE : S_START;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // The end of a stop bit pops directly, so back-to-back frames have no idle cycle between them.
  always_comb begin
    pop = 1'b0;
    TXD = 1'b1;
    case (state)
      S_IDLE: begin
        pop = ~empty;
        TXD = 1'b1;
      end
      S_START: begin
        TXD = 1'b0;
      end
      S_DATA: begin
        TXD = shift[0];
      end
      S_STOP: begin
        pop = tick & ~empty;
        TXD = 1'b1;
      end
      default: begin
        pop = 1'b0;
        TXD = 1'b1;
      end
    endcase
  end

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      timer  <= '0;
      bitidx <= '0;
      shift  <= '0;
    end else begin
      if (pop) begin
        timer <= TMAX;
      end else if (state == S_IDLE) begin
        timer <= '0;
      end else if (tick) begin
        timer <= TMAX;
      end else begin
        timer <= timer - T_ONE;
      end

      if (pop) begin
        shift <= mem[rd_ptr];
      end else if (state == S_DATA && tick) begin
        shift <= {1'b0, shift[7:1]};
      end

      if (state == S_DATA) begin
        if (tick) begin
          bitidx <= bitidx + 3'd1;
        end
      end else begin
        bitidx <= '0;
      end
    end
  end

endmodule

// File: tb/tb_m_wishbone_uarttx.sv
// Directed bench for m_wishbone_uarttx with DIVISOR=4, FIFOADRWIDTH=2.
// TXD and irq are logged per cycle; frames are compared against bit patterns built from the written bytes.
module tb_m_wishbone_uarttx;

  localparam int DIV   = 4;
  localparam int FAW   = 2;
  localparam int FRAME = 10 * DIV;
  localparam int LOGN  = 8192;

  logic        CLK_I = 1'b0;
  logic        RST_I = 1'b1;
  logic        STB_I = 1'b0;
  logic        WE_I  = 1'b0;
  logic        ADR_I = 1'b0;
  logic [3:0]  SEL_I = 4'h0;
  logic [31:0] DAT_I = 32'h0;
  logic        ACK_O;
  logic [31:0] DAT_O;
  logic        TXD;
  logic        irq;

  int checks = 0;
  int passed = 0;
  int cyc = 0;

  logic txd_log [LOGN];
  logic irq_log [LOGN];

  m_wishbone_uarttx #(.DIVISOR(DIV), .FIFOADRWIDTH(FAW)) dut (
    .CLK_I(CLK_I), .RST_I(RST_I), .STB_I(STB_I), .WE_I(WE_I), .ADR_I(ADR_I),
    .SEL_I(SEL_I), .DAT_I(DAT_I), .ACK_O(ACK_O), .DAT_O(DAT_O), .TXD(TXD), .irq(irq)
  );

  always #5 CLK_I = ~CLK_I;

  always @(posedge CLK_I) cyc <= cyc + 1;

  always @(negedge CLK_I) begin
    if (cyc < LOGN) begin
      txd_log[cyc] <= TXD;
      irq_log[cyc] <= irq;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "timeout");
  end

  function automatic logic [FRAME-1:0] exp_frame(input logic [7:0] b);
    logic [9:0] f;
    logic [FRAME-1:0] e;
    f = {1'b1, b, 1'b0};
    for (int i = 0; i < FRAME; i++) e[i] = f[i / DIV];
    return e;
  endfunction

  function automatic logic [FRAME-1:0] got_frame(input int s);
    logic [FRAME-1:0] r;
    for (int i = 0; i < FRAME; i++) r[i] = txd_log[s + i];
    return r;
  endfunction

  function automatic int count_not_idle(input int from, input int to);
    int n;
    n = 0;
    for (int c = from; c < to; c++) if (txd_log[c] !== 1'b1) n++;
    return n;
  endfunction

  task automatic reset_dut();
    STB_I = 1'b0; WE_I = 1'b0; ADR_I = 1'b0; SEL_I = 4'h0; DAT_I = 32'h0;
    RST_I = 1'b1;
    repeat (2) @(negedge CLK_I);
    RST_I = 1'b0;
    @(negedge CLK_I);
  endtask

  task automatic wait_to(input int target);
    while (cyc < target) @(negedge CLK_I);
  endtask

  task automatic bus_write(input logic adr, input logic [31:0] d, input logic [3:0] sel,
                           output logic ack1, output logic ack2);
    STB_I = 1'b1; WE_I = 1'b1; ADR_I = adr; SEL_I = sel; DAT_I = d;
    @(negedge CLK_I);
    ack1 = ACK_O;
    @(negedge CLK_I);
    ack2 = ACK_O;
    STB_I = 1'b0; WE_I = 1'b0;
  endtask

  task automatic bus_read(input logic adr, output logic [31:0] data, output logic ack1);
    STB_I = 1'b1; WE_I = 1'b0; ADR_I = adr; SEL_I = 4'hF;
    @(negedge CLK_I);
    ack1 = ACK_O;
    data = DAT_O;
    @(negedge CLK_I);
    STB_I = 1'b0;
  endtask

  task automatic test_reset();
    logic a1, a2;
    logic [31:0] d;
    reset_dut();
    checks++; if (TXD !== 1'b1) $display("FAIL reset_txd: got %b expected 1", TXD); else passed++;
    checks++; if (irq !== 1'b1) $display("FAIL reset_irq: got %b expected 1", irq); else passed++;
    checks++; if (ACK_O !== 1'b0) $display("FAIL reset_ack: got %b expected 0", ACK_O); else passed++;
    checks++; if (DAT_O !== 32'h0) $display("FAIL reset_dat: got %h expected 00000000", DAT_O); else passed++;
    bus_read(1'b1, d, a1);
    checks++; if (a1 !== 1'b1) $display("FAIL reset_status_ack: got %b expected 1", a1); else passed++;
    checks++; if (d !== 32'h4) $display("FAIL reset_status: got %h expected 00000004", d); else passed++;
    bus_read(1'b0, d, a1);
    checks++; if (d !== 32'h0) $display("FAIL data_read: got %h expected 00000000", d); else passed++;
    bus_write(1'b1, 32'hFF, 4'hF, a1, a2);
    checks++; if ({a1, a2} !== 2'b10) $display("FAIL status_write_ack: got %b expected 10", {a1, a2}); else passed++;
    bus_read(1'b1, d, a1);
    checks++; if (d !== 32'h4) $display("FAIL status_write_ignored: got %h expected 00000004", d); else passed++;
    $display("test_reset done: checks=%0d passed=%0d", checks, passed);
  endtask

  task automatic test_single_byte();
    logic a1, a2;
    int s;
    reset_dut();
    s = cyc;
    bus_write(1'b0, 32'hA5, 4'h1, a1, a2);
    checks++; if ({a1, a2} !== 2'b10) $display("FAIL a5_ack_pulse: got %b expected 10", {a1, a2}); else passed++;
    wait_to(s + 3 + FRAME + 2);
    checks++; if (txd_log[s + 2] !== 1'b1) $display("FAIL a5_latency_before: got %b expected 1", txd_log[s + 2]); else passed++;
    checks++;
    if (got_frame(s + 3) !== exp_frame(8'hA5))
      $display("FAIL a5_frame: got %h expected %h", got_frame(s + 3), exp_frame(8'hA5));
    else passed++;
    checks++; if (irq_log[s + 20] !== 1'b0) $display("FAIL a5_irq_mid: got %b expected 0", irq_log[s + 20]); else passed++;
    checks++; if (irq_log[s + 42] !== 1'b0) $display("FAIL a5_irq_stop: got %b expected 0", irq_log[s + 42]); else passed++;
    checks++; if (irq_log[s + 43] !== 1'b1) $display("FAIL a5_irq_after: got %b expected 1", irq_log[s + 43]); else passed++;
    $display("test_single_byte done: checks=%0d passed=%0d", checks, passed);
  endtask

  task automatic test_overflow();
    logic [7:0] bytes [6] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    logic a1, a2;
    logic [31:0] d;
    int s, bad;
    reset_dut();
    s = cyc;
    for (int k = 0; k < 6; k++) bus_write(1'b0, {24'h0, bytes[k]}, 4'h1, a1, a2);
    bus_read(1'b1, d, a1);
    checks++; if (d !== 32'h4B) $display("FAIL ovf_status_set: got %h expected 0000004b", d); else passed++;
    bus_read(1'b1, d, a1);
    checks++; if (d !== 32'h43) $display("FAIL ovf_status_cleared: got %h expected 00000043", d); else passed++;
    wait_to(s + 3 + 5 * FRAME + 40);
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (got_frame(s + 3 + k * FRAME) !== exp_frame(bytes[k]))
        $display("FAIL ovf_frame%0d: got %h expected %h", k, got_frame(s + 3 + k * FRAME), exp_frame(bytes[k]));
      else passed++;
    end
    bad = count_not_idle(s + 3 + 5 * FRAME, s + 3 + 5 * FRAME + 38);
    checks++; if (bad !== 0) $display("FAIL ovf_dropped_byte: got %0d non-idle cycles expected 0", bad); else passed++;
    $display("test_overflow done: checks=%0d passed=%0d", checks, passed);
  endtask

  task automatic test_full_pop();
    logic [7:0] bytes [6] = '{8'hC3, 8'h5A, 8'h0F, 8'hF0, 8'h81, 8'h7E};
    logic a1, a2;
    logic [31:0] d;
    int s, bad;
    reset_dut();
    s = cyc;
    for (int k = 0; k < 5; k++) bus_write(1'b0, {24'h0, bytes[k]}, 4'h1, a1, a2);
    // ack at s+42 so the push edge coincides with the pop that ends frame 0's stop bit
    wait_to(s + 41);
    bus_write(1'b0, {24'h0, bytes[5]}, 4'h1, a1, a2);
    checks++; if (a1 !== 1'b1) $display("FAIL fullpop_ack: got %b expected 1", a1); else passed++;
    bus_read(1'b1, d, a1);
    checks++; if (d !== 32'h43) $display("FAIL fullpop_status: got %h expected 00000043", d); else passed++;
    wait_to(s + 3 + 6 * FRAME + 20);
    for (int k = 0; k < 6; k++) begin
      checks++;
      if (got_frame(s + 3 + k * FRAME) !== exp_frame(bytes[k]))
        $display("FAIL fullpop_frame%0d: got %h expected %h", k, got_frame(s + 3 + k * FRAME), exp_frame(bytes[k]));
      else passed++;
    end
    bad = count_not_idle(s + 3 + 6 * FRAME, s + 3 + 6 * FRAME + 18);
    checks++; if (bad !== 0) $display("FAIL fullpop_tail_idle: got %0d non-idle cycles expected 0", bad); else passed++;
    $display("test_full_pop done: checks=%0d passed=%0d", checks, passed);
  endtask

  task automatic test_held_stb();
    logic a1;
    logic [31:0] d;
    int s, acks, bad;
    reset_dut();
    s = cyc;
    acks = 0;
    STB_I = 1'b1; WE_I = 1'b1; ADR_I = 1'b0; SEL_I = 4'h1; DAT_I = 32'h3C;
    repeat (4) begin
      @(negedge CLK_I);
      if (ACK_O === 1'b1) acks++;
    end
    STB_I = 1'b0; WE_I = 1'b0;
    checks++; if (acks !== 2) $display("FAIL held_ack_count: got %0d expected 2", acks); else passed++;
    bus_read(1'b1, d, a1);
    checks++; if (d !== 32'h11) $display("FAIL held_status: got %h expected 00000011", d); else passed++;
    wait_to(s + 3 + 2 * FRAME + 20);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (got_frame(s + 3 + k * FRAME) !== exp_frame(8'h3C))
        $display("FAIL held_frame%0d: got %h expected %h", k, got_frame(s + 3 + k * FRAME), exp_frame(8'h3C));
      else passed++;
    end
    bad = count_not_idle(s + 3 + 2 * FRAME, s + 3 + 2 * FRAME + 18);
    checks++; if (bad !== 0) $display("FAIL held_third_push: got %0d non-idle cycles expected 0", bad); else passed++;
    $display("test_held_stb done: checks=%0d passed=%0d", checks, passed);
  endtask

  task automatic test_reset_mid_frame();
    logic a1, a2;
    logic [31:0] d;
    int s, r, bad;
    reset_dut();
    s = cyc;
    bus_write(1'b0, 32'h00, 4'h1, a1, a2);
    bus_write(1'b0, 32'h81, 4'h1, a1, a2);
    wait_to(s + 12);
    checks++; if (TXD !== 1'b0) $display("FAIL midrst_pre_txd: got %b expected 0", TXD); else passed++;
    RST_I = 1'b1;
    #1;
    checks++; if (TXD !== 1'b1) $display("FAIL midrst_async_txd: got %b expected 1", TXD); else passed++;
    @(negedge CLK_I);
    RST_I = 1'b0;
    r = cyc;
    bus_read(1'b1, d, a1);
    checks++; if (d !== 32'h4) $display("FAIL midrst_status: got %h expected 00000004", d); else passed++;
    wait_to(r + 2 * FRAME);
    bad = count_not_idle(r, r + 2 * FRAME - 1);
    checks++; if (bad !== 0) $display("FAIL midrst_residual: got %0d non-idle cycles expected 0", bad); else passed++;
    $display("test_reset_mid_frame done: checks=%0d passed=%0d", checks, passed);
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_overflow();
    test_full_pop();
    test_held_stb();
    test_reset_mid_frame();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
